// File: rtl/extension_unit_pkg.sv
// Shared constants for the immediate extension unit: data width and the
// CEU immediate-format select encoding.
package extension_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    CEU_I     = 3'd0,
    CEU_S     = 3'd1,
    CEU_B     = 3'd2,
    CEU_U     = 3'd3,
    CEU_J     = 3'd4,
    CEU_SHAMT = 3'd5,
    CEU_ZIMM  = 3'd6,
    CEU_RSVD  = 3'd7
  } ceu_e;

endpackage

// File: rtl/extension_unit_decode.sv
// Combinational immediate-format decode. The 25-bit input carries
// instruction bits [31:7], so instr[k] is read as dint_i[k-7] throughout.
module extension_unit_decode
  import extension_unit_pkg::*;
(
  input  logic [2:0]  ceu_i,
  input  logic [24:0] dint_i,
  output logic [31:0] imm_o
);

  logic sgn;
  assign sgn = dint_i[24];

  // Select and sign/zero-extend the immediate for the requested format
  always_comb begin
    imm_o = '0;
    case (ceu_e'(ceu_i))
      CEU_I:     imm_o = {{20{sgn}}, dint_i[24:13]};
      CEU_S:     imm_o = {{20{sgn}}, dint_i[24:18], dint_i[4:0]};
      CEU_B:     imm_o = {{19{sgn}}, sgn, dint_i[0], dint_i[23:18], dint_i[4:1], 1'b0};
      CEU_U:     imm_o = {dint_i[24:5], 12'b0};
      CEU_J:     imm_o = {{11{sgn}}, sgn, dint_i[12:5], dint_i[13], dint_i[23:14], 1'b0};
      CEU_SHAMT: imm_o = {27'b0, dint_i[17:13]};
      CEU_ZIMM:  imm_o = {27'b0, dint_i[12:8]};
      default:   imm_o = '0;
    endcase
  end

endmodule

// File: rtl/extension_unit_core.sv
// Immediate extension unit: one-cycle registered decode of RISC-V style
// immediates with a valid qualifier and no backpressure.
// Optional feature: define EXTENSION_UNIT_ILLEGAL_FLAG_EN to add the
// registered 'illegal' output flagging the reserved CEU encoding.
module extension_unit_core #(
  parameter int XLEN = extension_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      CEU,
  input  logic [24:0]     Dint,
  output logic            out_valid,
`ifdef EXTENSION_UNIT_ILLEGAL_FLAG_EN
  output logic            illegal,
`endif
  output logic [XLEN-1:0] Dout
);

  import extension_unit_pkg::*;

  logic [31:0]     imm_d;
  logic [XLEN-1:0] dout_q;
  logic            out_valid_q;

  extension_unit_decode u_decode (
    .ceu_i  (CEU),
    .dint_i (Dint),
    .imm_o  (imm_d)
  );

  // Capture the decoded immediate on valid; hold it otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        dout_q <= imm_d[XLEN-1:0];
      end
    end
  end

  assign Dout      = dout_q;
  assign out_valid = out_valid_q;

`ifdef EXTENSION_UNIT_ILLEGAL_FLAG_EN
  logic illegal_d;
  logic illegal_q;

  assign illegal_d = in_valid && (CEU == CEU_RSVD);

  // Flag reserved-format samples alongside the result they produced
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_extension_unit_core.sv
// Self-checking bench for extension_unit_core: directed vectors plus random
// traffic compared against an arithmetic reference of the immediate formats.
module tb_extension_unit_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  CEU;
  logic [24:0] Dint;
  logic        out_valid;
  logic [31:0] Dout;
`ifdef EXTENSION_UNIT_ILLEGAL_FLAG_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_dout;
  logic        exp_valid;
  logic        exp_ill;

  extension_unit_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .CEU       (CEU),
    .Dint      (Dint),
    .out_valid (out_valid),
`ifdef EXTENSION_UNIT_ILLEGAL_FLAG_EN
    .illegal   (illegal),
`endif
    .Dout      (Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference: rebuild the full instruction word and extract fields arithmetically
  function automatic logic [31:0] ref_imm(input logic [2:0] ceu, input logic [24:0] d);
    logic [31:0] ins;
    logic [31:0] s;
    ins = {d, 7'b0};
    s   = 32'($signed(ins) >>> 31);
    case (ceu)
      3'd0: return 32'($signed(ins) >>> 20);
      3'd1: return (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 32'h1f);
      3'd2: return (s << 12) | (((ins >> 7) & 1) << 11) | (((ins >> 25) & 32'h3f) << 5)
                   | (((ins >> 8) & 32'hf) << 1);
      3'd3: return ins & 32'hFFFFF000;
      3'd4: return (s << 20) | (((ins >> 12) & 32'hff) << 12) | (((ins >> 20) & 1) << 11)
                   | (((ins >> 21) & 32'h3ff) << 1);
      3'd5: return (ins >> 20) & 32'h1f;
      3'd6: return (ins >> 15) & 32'h1f;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, "_dout"}, Dout, exp_dout);
    check_val({tag, "_valid"}, {31'b0, out_valid}, {31'b0, exp_valid});
`ifdef EXTENSION_UNIT_ILLEGAL_FLAG_EN
    check_val({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
`endif
  endtask

  // Drive one cycle of input, advance the model, compare after the edge
  task automatic step(input logic v, input logic [2:0] ceu, input logic [24:0] d, input string tag);
    @(negedge clk);
    in_valid = v;
    CEU      = ceu;
    Dint     = d;
    @(posedge clk);
    #1;
    exp_valid = v;
    exp_ill   = v && (ceu == 3'd7);
    if (v) exp_dout = ref_imm(ceu, d);
    check_outputs(tag);
  endtask

  logic [31:0] vec23 [8];

  initial begin
    vec23[0] = 32'hFFFFFAAA; vec23[1] = 32'hFFFFFAB5; vec23[2] = 32'hFFFFFAB4;
    vec23[3] = 32'hAAAAA000; vec23[4] = 32'hFFFAA2AA; vec23[5] = 32'h0000000A;
    vec23[6] = 32'h00000015; vec23[7] = 32'h00000000;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    CEU       = 3'd0;
    Dint      = 25'h1555555;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ill   = 1'b0;

    // Reset held with valid input: outputs stay cleared across edges
    repeat (3) @(posedge clk);
    #1;
    check_outputs("in_reset");
    #1 rst_n = 1'b1;

    // First edge after release registers the sample
    step(1'b1, 3'd0, 25'h1555555, "first_after_rst");
    check_val("first_after_rst_lit", Dout, 32'hFFFFFAAA);

    // All formats on the alternating pattern, back to back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 25'h1555555, $sformatf("alt_ceu%0d", i));
      check_val($sformatf("alt_lit%0d", i), Dout, vec23[i]);
    end

    // Positive sign bit
    step(1'b1, 3'd0, 25'h0AAAAAA, "pos_i");
    check_val("pos_i_lit", Dout, 32'h00000555);
    step(1'b1, 3'd3, 25'h0AAAAAA, "pos_u");
    check_val("pos_u_lit", Dout, 32'h55555000);

    // Valid pulse 1,0,1 with junk inputs while invalid
    step(1'b1, 3'd1, 25'h1234567, "pulse_a");
    step(1'b0, 3'd3, 25'h1FFFFFF, "pulse_gap");
    check_val("pulse_hold_lit", Dout, ref_imm(3'd1, 25'h1234567));
    step(1'b1, 3'd4, 25'h0F0F0F0, "pulse_b");

    // Asynchronous reset mid-cycle with a sample pending
    step(1'b1, 3'd2, 25'h1ABCDEF, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1;
    CEU      = 3'd0;
    Dint     = 25'h1555555;
    #1 rst_n = 1'b0;
    #1;
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ill   = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst_discard");
    #1 rst_n = 1'b1;
    step(1'b1, 3'd6, 25'h0123456, "post_rst");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           25'($urandom), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
